logic_unit_arbiter: RTL and testbench

- Shares one WIDTH-bit bitwise logic unit between NREQ requesters using round-robin arbitration.
- The unit supports the seven basic gate operations: AND, OR, NOT, NOR, XOR, XNOR, NAND.
- Each requester uses a valid/ready handshake to submit opcode and operands; one tagged, registered response returns per request with output backpressure.
- Sits between the control masters and the shared gate datapath; only one operation is in flight at a time.

---
 rtl/logic_op_pkg.sv | 19 +
 rtl/logic_unit.sv | 29 ++
 rtl/logic_unit_arbiter.sv | 134 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared constants for the round-robin logic unit arbiter: opcodes,
// opcode width and FSM state encodings.
package logic_op_pkg;

   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_AND  = 3'd0;
   localparam logic [OPW-1:0] OP_OR   = 3'd1;
   localparam logic [OPW-1:0] OP_NOT  = 3'd2;
   localparam logic [OPW-1:0] OP_NOR  = 3'd3;
   localparam logic [OPW-1:0] OP_XOR  = 3'd4;
   localparam logic [OPW-1:0] OP_XNOR = 3'd5;
   localparam logic [OPW-1:0] OP_NAND = 3'd6;
   localparam logic [OPW-1:0] OP_RSVD = 3'd7;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise gate unit; reserved opcode yields zero with err set.
module logic_unit
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);

   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NOT:  y = ~a;
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NAND: y = ~(a & b);
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters, with a
// single registered, tagged response held until the consumer accepts it.
module logic_unit_arbiter
   import logic_op_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [OPW*NREQ-1:0]   req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam int CW = IDW + 1;

   logic [0:0]       state_q, state_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [CW-1:0]    cand;
   logic [OPW-1:0]   op_g;
   logic [WIDTH-1:0] a_g, b_g, y_g;
   logic             err_g;

   // Scan starts just after the last winner so every requester gets a turn.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = {1'b0, last_grant_q} + CW'(k);
         if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
         if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == ST_IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      op_g = '0;
      a_g  = '0;
      b_g  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDW'(i) == gnt_idx) begin
            op_g = req_op[i*OPW +: OPW];
            a_g  = req_a[i*WIDTH +: WIDTH];
            b_g  = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
      .op  (op_g),
      .a   (a_g),
      .b   (b_g),
      .y   (y_g),
      .err (err_g)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               state_d      = ST_RESP;
               last_grant_d = gnt_idx;
               rsp_valid_d  = 1'b1;
               rsp_id_d     = gnt_idx;
               rsp_data_d   = y_g;
               rsp_err_d    = err_g;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = (state_q == ST_RESP);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a truth-table reference model
// predicts grants and responses; a separate monitor checks what the DUT returns.
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ-1:0]  req_ready;
   logic [3*NREQ-1:0] req_op;
   logic [WIDTH*NREQ-1:0] req_a, req_b;
   logic             rsp_valid, rsp_ready, rsp_err, busy;
   logic [IDW-1:0]   rsp_id;
   logic [WIDTH-1:0] rsp_data;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   int   obs_ids[$];

   logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Each gate as a 4-entry truth table indexed by {a_bit, b_bit}.
   function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
      logic [3:0] tt;
      logic [7:0] y;
      case (op)
         0: tt = 4'b1000;
         1: tt = 4'b1110;
         2: tt = 4'b0011;
         3: tt = 4'b0001;
         4: tt = 4'b0110;
         5: tt = 4'b1001;
         6: tt = 4'b0111;
         default: tt = 4'b0000;
      endcase
      for (int i = 0; i < 8; i++) y[i] = tt[{a[i], b[i]}];
      return y;
   endfunction

   // Reference model: busy flag, last winner and a modular scan.
   bit   m_busy = 0;
   int   m_last = NREQ - 1;
   bit   chk_rst = 0;
   int   m_g, m_c, m_op;
   exp_t m_e;

   always @(negedge clk) begin
      if (chk_rst) begin
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_rsp_data", rsp_data, 0);
         chk("rst_rsp_id", rsp_id, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk_rst = 0;
      end
      if (!rst_n) begin
         m_busy = 0;
         m_last = NREQ - 1;
         exp_q.delete();
         chk_rst = 1;
      end else if (!m_busy) begin
         m_g = -1;
         for (int k = 1; k <= NREQ; k++) begin
            m_c = (m_last + k) % NREQ;
            if (m_g < 0 && req_valid[m_c]) m_g = m_c;
         end
         chk("idle_req_ready", req_ready, (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
         chk("idle_busy", busy, 0);
         if (m_g >= 0) begin
            m_op   = int'(req_op[3*m_g +: 3]);
            m_e.id = m_g;
            m_e.data = ref_op(m_op, req_a[8*m_g +: 8], req_b[8*m_g +: 8]);
            m_e.err  = (m_op == 7);
            exp_q.push_back(m_e);
            m_last = m_g;
            m_busy = 1;
         end
      end else begin
         chk("resp_req_ready", req_ready, 0);
         chk("resp_busy", busy, 1);
         if (rsp_ready) m_busy = 0;
      end
   end

   // Monitor: pops on the first cycle of each response, then checks it holds.
   bit   hold = 0;
   exp_t cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 0;
      end else if (rsp_valid) begin
         if (!hold) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: got response id %0d, required none", rsp_id);
            end else begin
               cur = exp_q.pop_front();
               chk("rsp_id", rsp_id, cur.id);
               chk("rsp_data", rsp_data, cur.data);
               chk("rsp_err", rsp_err, cur.err);
               obs_ids.push_back(int'(rsp_id));
            end
            hold = 1;
         end else begin
            chk("hold_id", rsp_id, cur.id);
            chk("hold_data", rsp_data, cur.data);
            chk("hold_err", rsp_err, cur.err);
         end
         if (rsp_ready) hold = 0;
      end else begin
         hold = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3] = 3'(op);
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_ready(input int i);
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready[i] && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("grant_wait", req_ready[i], 1);
   endtask

   logic [7:0] sweep_exp [8];
   logic [7:0] cap;
   int         rr_exp [6];
   int         k, ones;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      sweep_exp = '{8'h05, 8'hAF, 8'h5A, 8'h50, 8'hAA, 8'h55, 8'hFA, 8'h00};
      rr_exp    = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
      do_reset();

      // Single AND request from requester 0
      set_req(0, 0, 8'hF0, 8'h3C);
      req_valid = 4'b0001;
      @(negedge clk);
      chk("first_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("first_valid", rsp_valid, 1);
      chk("first_data", rsp_data, 8'h30);
      chk("first_id", rsp_id, 0);
      chk("first_err", rsp_err, 0);
      tick();

      // Opcode sweep on requester 2
      for (int op = 0; op < 8; op++) begin
         set_req(2, op, 8'hA5, 8'h0F);
         req_valid = 4'b0100;
         wait_ready(2);
         tick();
         req_valid = '0;
         @(negedge clk);
         chk("sweep_data", rsp_data, sweep_exp[op]);
         chk("sweep_err", rsp_err, (op == 7));
         tick();
      end

      // Round-robin with all requesters active
      do_reset();
      obs_ids.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, 4, 8'($urandom), 8'($urandom));
      req_valid = 4'hF;
      k = 0;
      while (obs_ids.size() < 6 && k < 40) begin
         tick();
         k++;
      end
      req_valid = '0;
      chk("rr_count", (obs_ids.size() >= 6), 1);
      for (int i = 0; i < 6 && i < obs_ids.size(); i++) chk("rr_order", obs_ids[i], rr_exp[i]);
      repeat (4) tick();

      // Backpressure: hold response for 5 cycles with another requester waiting
      rsp_ready = 1'b0;
      set_req(1, 6, 8'h3C, 8'h5A);
      req_valid = 4'b0010;
      wait_ready(1);
      tick();
      set_req(3, 1, 8'h11, 8'h22);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      cap = rsp_data;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_valid_hold", rsp_valid, 1);
         chk("bp_data_hold", rsp_data, cap);
         chk("bp_ready_zero", req_ready, 0);
         chk("bp_busy", busy, 1);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_no_early_grant", req_ready, 0);
      @(negedge clk);
      chk("bp_next_grant", req_ready, 4'b1000);
      tick();
      req_valid = '0;
      repeat (3) tick();

      // Reset while a response is pending
      rsp_ready = 1'b0;
      set_req(2, 3, 8'h0F, 8'hF0);
      req_valid = 4'b0100;
      wait_ready(2);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("mid_rsp_valid", rsp_valid, 1);
      tick();
      rst_n = 1'b0;
      req_valid = 4'b1001;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", rsp_data, 0);
      chk("mid_rst_grant", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) tick();

      // Requester 1 withdraws its valid while requester 0 is answered
      obs_ids.delete();
      rsp_ready = 1'b0;
      set_req(0, 4, 8'h55, 8'hFF);
      set_req(1, 0, 8'hFF, 8'hFF);
      req_valid = 4'b0001;
      wait_ready(0);
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("wd_ready", req_ready, 0);
      tick();
      req_valid = '0;
      tick();
      rsp_ready = 1'b1;
      repeat (4) tick();
      ones = 0;
      foreach (obs_ids[i]) if (obs_ids[i] == 1) ones++;
      chk("wd_no_id1", ones, 0);
      chk("wd_rsp_count", obs_ids.size(), 1);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom);
         req_op    = 12'($urandom);
         req_a     = $urandom;
         req_b     = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (4) tick();
      chk("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
